// File: rtl/conv_pe_acc.sv
// ============================================================================
// Module   : conv_pe_acc
// Purpose  : Multi-channel convolution PE. It accumulates N_CH dot-products
//            over TAPS beats, then rounds, rescales, biases and saturates the
//            sum into a one-entry valid/ready output register.
// Option   : CONV_PE_RELU_EN clamps negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pe_acc #(
  parameter int DW    = 16,
  parameter int N_CH  = 3,
  parameter int TAPS  = 9,
  parameter int FRAC  = 10,
  parameter int ACC_W = 2*DW + $clog2(N_CH*TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*DW-1:0]   in_fmap,
  input  logic [N_CH*DW-1:0]   in_weight,
  input  logic [DW-1:0]        bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_sat,
  output logic                 busy
);

  localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2*DW;
  localparam int S_W    = ACC_W + 1;
  localparam int V_W    = S_W + 1;

  localparam logic [CNT_W-1:0]      c_last_tap = CNT_W'(TAPS-1);
  localparam logic signed [S_W-1:0] c_half     = S_W'(1) << (FRAC-1);
  localparam logic signed [V_W-1:0] c_max      = {{(V_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [V_W-1:0] c_min      = {{(V_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_beat_sum;
  logic signed [S_W-1:0]    w_win_sum;
  logic signed [S_W-1:0]    w_rounded;
  logic signed [S_W-1:0]    w_shifted;
  logic signed [V_W-1:0]    w_biased;
  logic [DW-1:0]            w_res;
  logic                     w_res_sat;
  logic                     w_last;
  logic                     w_accept;
  logic                     w_take;
  logic                     w_load;

  always_comb begin
    w_prod     = '0;
    w_beat_sum = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_prod     = $signed(in_fmap[c*DW +: DW]) * $signed(in_weight[c*DW +: DW]);
      w_beat_sum = w_beat_sum + ACC_W'(w_prod);
    end
  end

  // Widened by one bit so the rounding offset can never wrap the window sum.
  always_comb begin
    w_win_sum = S_W'(acc_q) + S_W'(w_beat_sum);
    w_rounded = w_win_sum + c_half;
    w_shifted = w_rounded >>> FRAC;
    w_biased  = V_W'(w_shifted) + V_W'($signed(bias));
  end

  always_comb begin
    w_res     = w_biased[DW-1:0];
    w_res_sat = 1'b0;
    if (w_biased > c_max) begin
      w_res     = {1'b0, {(DW-1){1'b1}}};
      w_res_sat = 1'b1;
    end else if (w_biased < c_min) begin
      w_res     = {1'b1, {(DW-1){1'b0}}};
      w_res_sat = 1'b1;
    end
`ifdef CONV_PE_RELU_EN
    if (w_biased[V_W-1]) begin
      w_res = '0;
    end
`else
`endif
  end

  // Only the closing tap needs the output slot, so earlier taps keep flowing
  // while a finished result waits for downstream.
  assign w_last   = (tap_cnt_q == c_last_tap);
  assign in_ready = !w_last || !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_take   = out_valid_q && out_ready;
  assign w_load   = w_accept && w_last;

  always_comb begin
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    if (flush) begin
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (w_accept) begin
      if (w_last) begin
        tap_cnt_d = '0;
        acc_d     = '0;
      end else begin
        tap_cnt_d = tap_cnt_q + 1'b1;
        acc_d     = acc_q + w_beat_sum;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (w_take) begin
      out_valid_d = 1'b0;
    end
    if (w_load) begin
      out_valid_d = 1'b1;
      out_data_d  = w_res;
      out_sat_d   = w_res_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (tap_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_conv_pe_acc.sv
// ============================================================================
// Module   : tb_conv_pe_acc
// Purpose  : Self-checking bench for conv_pe_acc with a window-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_pe_acc;

  localparam int DW   = 16;
  localparam int N_CH = 3;
  localparam int TAPS = 9;
  localparam int FRAC = 10;

  logic                 clk       = 1'b0;
  logic                 reset     = 1'b1;
  logic                 flush     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic                 out_ready = 1'b1;
  logic [N_CH*DW-1:0]   in_fmap   = '0;
  logic [N_CH*DW-1:0]   in_weight = '0;
  logic [DW-1:0]        bias      = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_sat;
  logic                 busy;

  always #5 clk = ~clk;

  conv_pe_acc #(.DW(DW), .N_CH(N_CH), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmap   (in_fmap),
    .in_weight (in_weight),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Window-level reference: running sum and beat count, one result slot.
  longint m_sum  = 0;
  int     m_cnt  = 0;
  bit     m_ov   = 1'b0;
  longint m_data = 0;
  bit     m_sat  = 1'b0;

  function automatic longint dot(input logic [N_CH*DW-1:0] f, input logic [N_CH*DW-1:0] w);
    longint s;
    s = 0;
    for (int c = 0; c < N_CH; c++)
      s += longint'($signed(f[c*DW +: DW])) * longint'($signed(w[c*DW +: DW]));
    return s;
  endfunction

  task automatic finish_window(input longint s, input longint b, output longint d, output bit sat);
    longint r, v, hi, lo;
    r   = (s + (longint'(1) << (FRAC-1))) >>> FRAC;
    v   = r + b;
    hi  = (longint'(1) << (DW-1)) - 1;
    lo  = -(longint'(1) << (DW-1));
    sat = 1'b0;
    d   = v;
    if (v > hi) begin d = hi; sat = 1'b1; end
    else if (v < lo) begin d = lo; sat = 1'b1; end
`ifdef CONV_PE_RELU_EN
    if (v < 0) d = 0;
`else
`endif
  endtask

  function automatic bit model_ready();
    return (m_cnt != TAPS-1) || !m_ov || out_ready;
  endfunction

  always @(posedge clk) begin : mdl
    bit ir;
    if (reset) begin
      m_sum = 0; m_cnt = 0; m_ov = 1'b0; m_data = 0; m_sat = 1'b0;
    end else begin
      ir = model_ready();
      if (m_ov && out_ready) m_ov = 1'b0;
      if (flush) begin
        m_sum = 0; m_cnt = 0;
      end else if (in_valid && ir) begin
        m_sum += dot(in_fmap, in_weight);
        m_cnt++;
        if (m_cnt == TAPS) begin
          finish_window(m_sum, longint'($signed(bias)), m_data, m_sat);
          m_ov  = 1'b1;
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("in_ready", in_ready, model_ready());
    chk("busy", busy, m_cnt != 0);
    if (m_ov) begin
      chk("out_data", longint'($signed(out_data)), m_data);
      chk("out_sat", out_sat, m_sat);
    end
  endtask

  task automatic set_beat(input int f, input int w);
    for (int c = 0; c < N_CH; c++) begin
      in_fmap[c*DW +: DW]   = DW'(f);
      in_weight[c*DW +: DW] = DW'(w);
    end
  endtask

  task automatic rand_beat();
    for (int c = 0; c < N_CH; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        in_fmap[c*DW +: DW]   = DW'($urandom);
        in_weight[c*DW +: DW] = DW'($urandom);
      end else begin
        in_fmap[c*DW +: DW]   = DW'(int'($urandom_range(0, 4095)) - 2048);
        in_weight[c*DW +: DW] = DW'(int'($urandom_range(0, 4095)) - 2048);
      end
    end
    bias = DW'($urandom);
  endtask

  // Full window of identical beats; bias only matters on the closing tap.
  task automatic run_window(input int f, input int w, input int b);
    for (int t = 0; t < TAPS; t++) begin
      set_beat(f, w);
      bias     = (t == TAPS-1) ? DW'(b) : DW'($urandom);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    cyc();

    run_window(1024, 1024, 0);
    chk("unity_valid", out_valid, 1);
    chk("unity_data", longint'($signed(out_data)), 27648);
    chk("unity_sat", out_sat, 0);
    cyc();

    for (int t = 0; t < TAPS; t++) begin
      set_beat(0, 0);
      if (t == 0) begin
        in_fmap[DW-1:0]   = DW'(1);
        in_weight[DW-1:0] = DW'(512);
      end
      bias     = (t == TAPS-1) ? DW'(-3) : DW'(100);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("round_data", longint'($signed(out_data)), -2);
    chk("round_sat", out_sat, 0);
    cyc();

    run_window(32767, 32767, 0);
    chk("sat_pos_data", longint'($signed(out_data)), 32767);
    chk("sat_pos_flag", out_sat, 1);
    cyc();
    run_window(-32768, 32767, 0);
`ifdef CONV_PE_RELU_EN
    chk("sat_neg_data", longint'($signed(out_data)), 0);
`else
    chk("sat_neg_data", longint'($signed(out_data)), -32768);
`endif
    chk("sat_neg_flag", out_sat, 1);
    cyc();

    // Back-pressure: eight taps accumulate, the closing tap waits for the slot.
    run_window(1024, 1024, 0);
    out_ready = 1'b0;
    set_beat(1024, 1024);
    bias     = '0;
    in_valid = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      chk("bp_in_ready", in_ready, (i < TAPS-1) ? 1 : 0);
      cyc();
    end
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", longint'($signed(out_data)), 27648);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    cyc();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", longint'($signed(out_data)), 27648);
    in_valid = 1'b0;
    cyc();
    chk("bp_drained", out_valid, 0);

    // Flush mid-window drops the offered beat but keeps a pending result.
    out_ready = 1'b0;
    run_window(1024, 1024, 5);
    for (int i = 0; i < 4; i++) begin
      set_beat(1024, 1024);
      in_valid = 1'b1;
      cyc();
    end
    flush = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_keep_valid", out_valid, 1);
    chk("flush_keep_data", longint'($signed(out_data)), 27653);
    out_ready = 1'b1;
    cyc();
    run_window(1024, 1024, 0);
    chk("flush_unity", longint'($signed(out_data)), 27648);
    cyc();

    for (int i = 0; i < 4; i++) begin
      set_beat(1024, 1024);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rstmid_busy", busy, 0);
    run_window(1024, 1024, 0);
    chk("rstmid_unity", longint'($signed(out_data)), 27648);
    cyc();

    // Streaming: continuous beats give a result pulse every TAPS cycles.
    out_ready = 1'b1;
    for (int k = 1; k <= 3*TAPS; k++) begin
      rand_beat();
      in_valid = 1'b1;
      cyc();
      chk("stream_pulse", out_valid, (k % TAPS == 0) ? 1 : 0);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_end", out_valid, 0);

    for (int n = 0; n < 400; n++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
